// File: rtl/seg7_pkg.sv
// Shared types and the seven-segment glyph table for the scan driver.
// Glyphs are active-low with bit order g..a.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t SEG_CODE [0:15] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder; codes 10-15 render blank unless hex
// rendering is enabled, and an explicit blank request always wins.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       hex_mode_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_CODE[nibble_i];
        if (blank_i || (!hex_mode_i && (nibble_i > 4'd9))) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: latches a packed nibble
// word on load and drives one digit per prescaler slot through registered outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int HEX_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = idx_width(TICK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic                    lz_q;
    seg7_t                   seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   nz_from;
    logic [3:0]              sel_nib;
    logic                    sel_blank;
    seg7_t                   dec_seg;

    assign tick = en && (presc_q == LAST_PRE);

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // nz_from[i] is set when nibble i or any higher nibble is non-zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]     = value_q[4*gi +: 4];
            assign nz_from[gi] = |value_q[4*NUM_DIGITS-1:4*gi];
            assign an_d[gi]    = !(en && (idx_q == IDX_W'(gi)));
        end
    endgenerate

    assign sel_nib   = nib[idx_q];
    assign sel_blank = lz_q && (idx_q != '0) && !nz_from[idx_q];

    seg7_decode u_decode (
        .nibble_i   (sel_nib),
        .blank_i    (sel_blank),
        .hex_mode_i (HEX_MODE != 0),
        .seg_o      (dec_seg)
    );

    // The decimal point ignores leading-zero blanking on purpose.
    assign seg_d = en ? dec_seg : SEG_BLANK;
    assign dp_d  = en ? ~dp_sh_q[idx_q] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            value_q <= '0;
            dp_sh_q <= '0;
            lz_q    <= 1'b0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= '1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (load) begin
                value_q <= value;
                dp_sh_q <= dp_in;
                lz_q    <= lz_en;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Random and directed stimulus for two driver instances (decimal and hex glyphs)
// checked every cycle against a counting-based reference model.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst, en, load, lz_en;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic [6:0]    seg_dec, seg_hex;
    logic          dp_dec, dp_hex;
    logic [3:0]    an_dec, an_hex;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: scan position is derived purely from the number of enabled edges.
    int          en_cnt = 0;
    logic [15:0] m_val  = '0;
    logic [3:0]  m_dp   = '0;
    logic        m_lz   = 1'b0;
    logic [6:0]  e_seg_dec, e_seg_hex;
    logic        e_dp;
    logic [3:0]  e_an;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .TICK_DIV(TD), .HEX_MODE(0)) u_dut_dec (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .seg(seg_dec), .dp(dp_dec), .an(an_dec)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .TICK_DIV(TD), .HEX_MODE(1)) u_dut_hex (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .seg(seg_hex), .dp(dp_hex), .an(an_hex)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            4'd10: return hex ? 7'b0001000 : 7'b1111111;
            4'd11: return hex ? 7'b0000011 : 7'b1111111;
            4'd12: return hex ? 7'b1000110 : 7'b1111111;
            4'd13: return hex ? 7'b0100001 : 7'b1111111;
            4'd14: return hex ? 7'b0000110 : 7'b1111111;
            default: return hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i, input logic lz, input bit hex);
        logic [15:0] upper;
        upper = v >> (4 * i);
        if (lz && (i > 0) && (upper == 16'd0)) return 7'b1111111;
        return glyph(upper[3:0], hex);
    endfunction

    function automatic int model_idx();
        return (en_cnt / TD) % ND;
    endfunction

    function automatic int model_phase();
        return en_cnt % TD;
    endfunction

    // One clock: predict outputs from pre-edge state, update model, compare after the edge.
    task automatic cycle();
        int i;
        logic [3:0] one;
        i = model_idx();
        one = 4'b0001;
        if (rst) begin
            e_an = 4'hF; e_seg_dec = 7'h7F; e_seg_hex = 7'h7F; e_dp = 1'b1;
            en_cnt = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        end else begin
            if (en) begin
                e_an      = ~(one << i);
                e_seg_dec = exp_seg(m_val, i, m_lz, 1'b0);
                e_seg_hex = exp_seg(m_val, i, m_lz, 1'b1);
                e_dp      = ~m_dp[i];
                en_cnt++;
            end else begin
                e_an = 4'hF; e_seg_dec = 7'h7F; e_seg_hex = 7'h7F; e_dp = 1'b1;
            end
            if (load) begin
                m_val = value; m_dp = dp_in; m_lz = lz_en;
                $display("load value=%h dp_in=%b lz_en=%b en=%b t=%0t", value, dp_in, lz_en, en, $time);
            end
        end
        @(posedge clk);
        #1;
        check("an_dec", 32'(an_dec), 32'(e_an));
        check("an_hex", 32'(an_hex), 32'(e_an));
        check("seg_dec", 32'(seg_dec), 32'(e_seg_dec));
        check("seg_hex", 32'(seg_hex), 32'(e_seg_hex));
        check("dp_dec", 32'(dp_dec), 32'(e_dp));
        check("dp_hex", 32'(dp_hex), 32'(e_dp));
    endtask

    task automatic drive(input logic r, input logic e, input logic l,
                         input logic [15:0] v, input logic [3:0] d, input logic z);
        rst = r; en = e; load = l; value = v; dp_in = d; lz_en = z;
        cycle();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
        @(negedge clk);
        idle(3);
        rst = 1'b0;
        idle(20);

        drive(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 1'b0);
        idle(16);
        drive(1'b0, 1'b1, 1'b1, 16'h0007, 4'b0000, 1'b1);
        idle(16);
        drive(1'b0, 1'b1, 1'b1, 16'h0000, 4'b1000, 1'b1);
        idle(16);
        drive(1'b0, 1'b1, 1'b1, 16'hABCF, 4'b0001, 1'b0);
        idle(16);

        // Freeze mid-slot at digit 2.
        for (int k = 0; k < 40 && !(model_idx() == 2 && model_phase() == 1); k++) cycle();
        en = 1'b0;
        idle(10);
        en = 1'b1;
        idle(16);

        // Load on the same edge as a tick, then reset mid-scan.
        for (int k = 0; k < 8 && model_phase() != TD - 1; k++) cycle();
        drive(1'b0, 1'b1, 1'b1, 16'h5678, 4'b0010, 1'b0);
        idle(6);
        drive(1'b1, 1'b1, 1'b1, 16'h9999, 4'b1111, 1'b1);
        idle(10);

        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom),
                  1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
